// File: rtl/draw_mode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : draw_mode_ctrl_pkg
// Purpose  : Shared types for the draw-mode sequencer: screen modes, the
//            sequencer state encoding and the default black-frame count.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package draw_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } game_mode;

  typedef enum logic [1:0] {
    DMC_STABLE    = 2'd0,
    DMC_WAIT_EDGE = 2'd1,
    DMC_BLANK     = 2'd2
  } draw_ctrl_state_e;

  localparam int DRAW_BLANK_FRAMES = 2;

endpackage
`default_nettype wire

// File: rtl/draw_mode_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : draw_mode_ctrl_if
// Purpose  : Bundles the mode request / frame timing inputs and the
//            committed-mode outputs of the draw-mode sequencer.
// Ports    : master - game FSM + timing side (drives mode_req, vblnk)
//            slave  - sequencer side (drives mode_o, blank_o, busy, done)
// Revision : 1.0 - initial release
// ============================================================================
interface draw_mode_ctrl_if;
  import draw_mode_ctrl_pkg::*;

  game_mode mode_req;
  logic     vblnk;
  game_mode mode_o;
  logic     blank_o;
  logic     busy;
  logic     done;

  modport master (
    output mode_req,
    output vblnk,
    input  mode_o,
    input  blank_o,
    input  busy,
    input  done
  );

  modport slave (
    input  mode_req,
    input  vblnk,
    output mode_o,
    output blank_o,
    output busy,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/frame_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : frame_edge_det
// Purpose  : Detects the rising edge of vertical blank (start of a frame
//            boundary).
// Ports    : clk, rst (sync, active-high)
//            vblnk  - vertical blank from the timing generator
//            fe     - high for the single cycle where vblnk rises
// Revision : 1.0 - initial release
// ============================================================================
module frame_edge_det (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic vblnk,
  output logic      fe
);

  logic vb_d_q;
  logic vb_d_d;

  always_comb begin
    vb_d_d = vblnk;
  end

  // Resetting the history to 1 suppresses a false edge when reset is
  // released in the middle of a blanking interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      vb_d_q <= 1'b1;
    end else begin
      vb_d_q <= vb_d_d;
    end
  end

  assign fe = vblnk & ~vb_d_q;

endmodule
`default_nettype wire

// File: rtl/draw_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : draw_mode_ctrl
// Purpose  : Frame-synchronous mode sequencer for the draw mux. Commits a
//            new screen mode only at a vblank rising edge and inserts
//            BLANK_FRAMES all-black frames between screens.
// Ports    : clk, rst (sync, active-high)
//            bus.mode_req (in)  requested mode, level, may change any cycle
//            bus.vblnk    (in)  vertical blank
//            bus.mode_o   (out) committed mode (mux select)
//            bus.blank_o  (out) force mux RGB to zero
//            bus.busy     (out) switch pending or in progress
//            bus.done     (out) 1-cycle pulse when mode_o is committed
// Revision : 1.0 - initial release
// ============================================================================
module draw_mode_ctrl
  import draw_mode_ctrl_pkg::*;
#(
  parameter int       BLANK_FRAMES = DRAW_BLANK_FRAMES,
  parameter game_mode RESET_MODE   = MENU
) (
  input  wire logic         clk,
  input  wire logic         rst,
  draw_mode_ctrl_if.slave   bus
);

  localparam logic [1:0] ST_STABLE    = DMC_STABLE;
  localparam logic [1:0] ST_WAIT_EDGE = DMC_WAIT_EDGE;
  localparam logic [1:0] ST_BLANK     = DMC_BLANK;

  localparam int FCNT_W = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  // Only meaningful when BLANK_FRAMES > 0; the zero case never reaches BLANK.
  localparam logic [FCNT_W-1:0] FCNT_LAST =
    (BLANK_FRAMES > 0) ? FCNT_W'(BLANK_FRAMES - 1) : '0;

  logic              fe;
  logic [1:0]        state_q, state_d;
  game_mode          mode_q,  mode_d;
  game_mode          tgt_q,   tgt_d;
  logic [FCNT_W-1:0] fcnt_q,  fcnt_d;
  logic              blank_q, blank_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  frame_edge_det u_edge (
    .clk   (clk),
    .rst   (rst),
    .vblnk (bus.vblnk),
    .fe    (fe)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    tgt_d   = tgt_q;
    fcnt_d  = fcnt_q;
    blank_d = blank_q;
    done_d  = 1'b0;

    case (state_q)
      ST_STABLE: begin
        if (bus.mode_req != mode_q) begin
          tgt_d   = bus.mode_req;
          state_d = ST_WAIT_EDGE;
        end
      end

      ST_WAIT_EDGE: begin
        tgt_d = bus.mode_req;
        if (bus.mode_req == mode_q) begin
          state_d = ST_STABLE;
        end else if (fe && (BLANK_FRAMES == 0)) begin
          mode_d  = tgt_d;
          done_d  = 1'b1;
          state_d = ST_STABLE;
        end else if (fe) begin
          blank_d = 1'b1;
          fcnt_d  = '0;
          state_d = ST_BLANK;
        end
      end

      ST_BLANK: begin
        // Last request wins; the blank run always completes, even when the
        // final target equals the mode already on screen.
        tgt_d = bus.mode_req;
        if (fe) begin
          if (fcnt_q == FCNT_LAST) begin
            mode_d  = tgt_d;
            blank_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_STABLE;
          end else if (fcnt_q != '1) begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_STABLE;
        blank_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_STABLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STABLE;
      mode_q  <= RESET_MODE;
      tgt_q   <= RESET_MODE;
      fcnt_q  <= '0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tgt_q   <= tgt_d;
      fcnt_q  <= fcnt_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.mode_o  = mode_q;
  assign bus.blank_o = blank_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_mode_ctrl
// Purpose  : Directed bench for draw_mode_ctrl. Two instances share one
//            stimulus stream: dut_a with BLANK_FRAMES=2, dut_b with
//            BLANK_FRAMES=0. Frame period 100 clk, vblnk high in 80..99.
//            Cycle 0 is the first cycle with rst low; values observed at
//            cycle N are the registered outputs after the edge closing N-1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_mode_ctrl;
  import draw_mode_ctrl_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  game_mode mode_req = MENU;
  logic     vblnk = 1'b0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int done_a_cnt = 0;
  int blank_a_cnt = 0;
  int done_b_cnt = 0;
  int blank_b_cnt = 0;

  draw_mode_ctrl_if if_a ();
  draw_mode_ctrl_if if_b ();

  assign if_a.mode_req = mode_req;
  assign if_a.vblnk    = vblnk;
  assign if_b.mode_req = mode_req;
  assign if_b.vblnk    = vblnk;

  draw_mode_ctrl #(.BLANK_FRAMES(2), .RESET_MODE(MENU)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  draw_mode_ctrl #(.BLANK_FRAMES(0), .RESET_MODE(MENU)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    vblnk = ((cyc % 100) >= 80);
    if (if_a.done    === 1'b1) done_a_cnt++;
    if (if_a.blank_o === 1'b1) blank_a_cnt++;
    if (if_b.done    === 1'b1) done_b_cnt++;
    if (if_b.blank_o === 1'b1) blank_b_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    mode_req = MENU;
    vblnk    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_mode_a",  if_a.mode_o,  MENU);
      chk("rst_blank_a", if_a.blank_o, 1'b0);
      chk("rst_busy_a",  if_a.busy,    1'b0);
      chk("rst_done_a",  if_a.done,    1'b0);
      chk("rst_mode_b",  if_b.mode_o,  MENU);
    end
    rst         = 1'b0;
    cyc         = 0;
    vblnk       = 1'b0;
    done_a_cnt  = 0;
    blank_a_cnt = 0;
    done_b_cnt  = 0;
    blank_b_cnt = 0;
  endtask

  initial begin
    // Reset, idle for 3 frames
    do_reset();
    run_to(300);
    chk("idle_mode",  if_a.mode_o, MENU);
    chk("idle_busy",  if_a.busy,   1'b0);
    chk("idle_done",  done_a_cnt,  0);
    chk("idle_blank", blank_a_cnt, 0);

    // Basic switch, BLANK_FRAMES=2
    do_reset();
    run_to(10);
    mode_req = GAME;
    chk("basic_busy_pre", if_a.busy, 1'b0);
    run_to(11);
    chk("basic_busy", if_a.busy, 1'b1);
    run_to(80);
    chk("basic_blank_pre", if_a.blank_o, 1'b0);
    run_to(81);
    chk("basic_blank", if_a.blank_o, 1'b1);
    run_to(280);
    chk("basic_mode_pre", if_a.mode_o, MENU);
    chk("basic_done_pre", if_a.done,   1'b0);
    run_to(281);
    chk("basic_mode",  if_a.mode_o,  GAME);
    chk("basic_blank_fall", if_a.blank_o, 1'b0);
    chk("basic_done",  if_a.done,    1'b1);
    chk("basic_busy_fall", if_a.busy, 1'b0);
    run_to(282);
    chk("basic_done_clr", if_a.done, 1'b0);
    run_to(400);
    chk("basic_done_cnt", done_a_cnt, 1);

    // Abort in WAIT_EDGE
    do_reset();
    run_to(10);
    mode_req = GAME;
    run_to(40);
    mode_req = MENU;
    chk("abort_busy_hold", if_a.busy, 1'b1);
    run_to(41);
    chk("abort_busy_fall", if_a.busy, 1'b0);
    run_to(300);
    chk("abort_blank_cnt", blank_a_cnt, 0);
    chk("abort_done_cnt",  done_a_cnt,  0);
    chk("abort_mode",      if_a.mode_o, MENU);

    // Last request wins while blanking
    do_reset();
    run_to(10);
    mode_req = GAME;
    run_to(150);
    mode_req = WIN;
    chk("lw_blank_mid", if_a.blank_o, 1'b1);
    run_to(281);
    chk("lw_mode", if_a.mode_o, WIN);
    chk("lw_done", if_a.done,   1'b1);
    run_to(400);
    chk("lw_done_cnt", done_a_cnt, 1);

    // BLANK_FRAMES=0 instance
    do_reset();
    run_to(10);
    mode_req = LOSE;
    run_to(80);
    chk("bf0_mode_pre", if_b.mode_o, MENU);
    run_to(81);
    chk("bf0_mode", if_b.mode_o, LOSE);
    chk("bf0_done", if_b.done,   1'b1);
    run_to(200);
    chk("bf0_blank_cnt", blank_b_cnt, 0);
    chk("bf0_done_cnt",  done_b_cnt,  1);

    // Reset mid-BLANK
    do_reset();
    run_to(10);
    mode_req = GAME;
    run_to(150);
    chk("rmid_blank_pre", if_a.blank_o, 1'b1);
    rst = 1'b1;
    tick();
    chk("rmid_blank", if_a.blank_o, 1'b0);
    chk("rmid_mode",  if_a.mode_o,  MENU);
    chk("rmid_busy",  if_a.busy,    1'b0);
    chk("rmid_done",  if_a.done,    1'b0);
    rst = 1'b0;
    tick();
    chk("rmid_busy_again", if_a.busy, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/draw_mode_ctrl.md
# draw_mode_ctrl

Frame-synchronous mode sequencer for the top-level draw mux. Game logic may change the requested `game_mode` at any clock. This block commits a new mode only at a vertical-blanking boundary and inserts a configurable number of full black frames between screens, so the display never shows a torn or mixed frame. It sits between the game FSM and the draw mux. Its `mode_o` drives the mux select, and its `blank_o` forces the mux RGB output to `'0`.

## Interface
Parameters:
- `BLANK_FRAMES`, default 2: number of all-black frames inserted per mode switch. Legal range 0..15.
- `RESET_MODE`, default `MENU`: value of `mode_o` after reset.

Ports:
- `clk` (in, 1): pixel clock, same clock as the draw pipeline.
- `rst` (in, 1): reset, synchronous, active-high.
- `mode_req` (in, `game_mode`): mode requested by the game FSM. Level input; may change on any cycle.
- `vblnk` (in, 1): vertical blank from the timing generator (`vga_in.vblnk`).
- `mode_o` (out, `game_mode`): committed mode, driving the draw mux select.
- `blank_o` (out, 1): while 1, the mux outputs RGB `'0`.
- `busy` (out, 1): a switch is pending or in progress.
- `done` (out, 1): one-cycle pulse on the cycle `mode_o` takes a new committed value.

## Operation
- Frame edge:
  - `vb_d` is `vblnk` registered.
  - `fe = vblnk & ~vb_d` (rising edge of `vblnk`).
  - `vb_d` resets to 1, so no edge is detected in the first cycle after reset.
- Target register `tgt` (`game_mode`): loaded from `mode_req` in every state except STABLE.
- Frame counter `fcnt`: width `$clog2(BLANK_FRAMES+1)`, minimum 1 bit. Saturates, never wraps.
- States and transitions:
  - STABLE:
    - `busy=0`, `blank_o=0`.
    - If `mode_req != mode_o`: load `tgt`, go to WAIT_EDGE.
  - WAIT_EDGE:
    - `busy=1`, `blank_o=0`.
    - If `mode_req == mode_o`: abort to STABLE. No blank, no `done`.
    - Else if `fe` and `BLANK_FRAMES == 0`: commit `mode_o <= mode_req`, pulse `done`, go to STABLE.
    - Else if `fe`: `blank_o <= 1`, `fcnt <= 0`, go to BLANK.
  - BLANK:
    - `busy=1`, `blank_o=1`.
    - `tgt` tracks `mode_req` (last request wins).
    - On `fe` with `fcnt == BLANK_FRAMES-1`: commit `mode_o <= mode_req`, `blank_o <= 0`, pulse `done`, go to STABLE.
    - On any other `fe`: `fcnt++`.
    - No abort from BLANK: the blank sequence always completes.
    - If the final target equals the old mode, `mode_o` keeps its value and `done` still pulses.
- Simultaneous events:
  - When `fe` coincides with a `mode_req` change, the value of `mode_req` sampled in that cycle is the one committed.
  - A request that changes again in the commit cycle is seen in STABLE on the next cycle and starts a new switch.
- Reset mid-switch: all state returns to reset values at once. Outputs: `mode_o=RESET_MODE`, `blank_o=0`, `busy=0`, `done=0`, `fcnt=0`, state STABLE.

## Timing
- All outputs are registered. No combinational path from input to output.
- `busy` rises 1 cycle after `mode_req` first differs from `mode_o`.
- `blank_o` rises 1 cycle after the first `fe` following the request. This is inside vblank, so the next active frame is fully black.
- `mode_o` updates and `done` pulses 1 cycle after the (BLANK_FRAMES+1)-th `fe` counted from the request. `blank_o` falls in the same cycle.
- Switch latency: between BLANK_FRAMES and BLANK_FRAMES+1 frame periods, plus 1 clk.
- Downstream requirement: the draw sub-pipelines are delay-matched (SUM_DELAY). Because every change occurs inside vblank, there are at least SUM_DELAY cycles before active video. vblank length is far greater than SUM_DELAY.

## Structure
- snake_pkg gains:
  - `typedef enum logic [1:0] {DMC_STABLE, DMC_WAIT_EDGE, DMC_BLANK} draw_ctrl_state_e`
  - `localparam int DRAW_BLANK_FRAMES = 2`
- One sub-module, `frame_edge_det` (clk, rst, `vblnk` → `fe`), which owns `vb_d` and its reset-to-1 rule.
- FSM, counter and target registers stay in `draw_mode_ctrl`.
- The integrating module gates its `rgb_nxt` to `'0` when `blank_o` is 1.

## Test plan
Frame period shortened in the bench: 100 clk, with `vblnk` high for cycles 80–99.

- Reset with `mode_req=MENU`:
  - Stimulus: hold `rst` 3 cycles.
  - Required: `mode_o=MENU`, `blank_o=0`, `busy=0`, `done=0` during and after reset; no `done` over 3 frames.
- Basic switch, `BLANK_FRAMES=2`:
  - Stimulus: `mode_req=GAME` at cycle 10.
  - Required: `busy=1` at cycle 11; `blank_o=1` at 81; `mode_o=GAME`, `blank_o=0` and `done` for exactly 1 cycle at 281.
- Abort in WAIT_EDGE:
  - Stimulus: `GAME` at cycle 10, back to `MENU` at cycle 40.
  - Required: `busy` falls at 41; `blank_o` never asserts; `mode_o` stays `MENU`; no `done`.
- Last request wins in BLANK:
  - Stimulus: `GAME` at cycle 10, `WIN` at cycle 150.
  - Required: commit at 281 with `mode_o=WIN`; exactly one `done`.
- `BLANK_FRAMES=0`:
  - Stimulus: `LOSE` at cycle 10.
  - Required: `mode_o=LOSE` and `done` at 81; `blank_o` never 1.
- Reset mid-BLANK:
  - Stimulus: `rst` at cycle 150.
  - Required: cycle 151 `blank_o=0`, `mode_o=MENU`, `busy=0`; with `mode_req` still `GAME`, `busy=1` again 1 cycle after `rst` deasserts.
